spi_tx_arbiter: RTL and testbench

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_tx_arb_pkg.sv | 9 +
 rtl/spi_tx_arb_port.sv | 46 ++++
 rtl/spi_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_spi_tx_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_arb_pkg.sv
// spi_tx_arb_pkg: shared types and constants for the two-client SPI transmit arbiter
package spi_tx_arb_pkg;
  localparam int N_CLIENTS = 2;
  typedef logic [$clog2(N_CLIENTS)-1:0] client_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  function automatic logic [N_CLIENTS-1:0] onehot(input client_t c);
    return N_CLIENTS'(1) << c;
  endfunction
endpackage

// File: rtl/spi_tx_arb_port.sv
// spi_tx_arb_port: per-client pending slot; accepts a byte when idle and reports busy until the arbiter retires it
module spi_tx_arb_port
  import spi_tx_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              dc_i,
  input  logic              done_i,
  output logic              tx_busy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              dc_o
);
  logic              pend_q, pend_d, dc_q, dc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  assign accept = tx_start_i && !pend_q;

  // latch byte on acceptance; slot stays pending until the arbiter retires it
  always_comb begin
    pend_d = accept | (pend_q & ~done_i);
    data_d = accept ? tx_data_i : data_q;
    dc_d   = accept ? dc_i : dc_q;
  end

  // slot registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      data_q <= '0;
      dc_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      dc_q   <= dc_d;
    end
  end

  assign tx_busy_o = pend_q;
  assign data_o    = data_q;
  assign dc_o      = dc_q;
endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI master between two clients; define SPI_TX_ARB_LOCK_EN to honour burst locks
module spi_tx_arbiter
  import spi_tx_arb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IDLE_CS_HOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_tx_start,
  input  logic [DATA_W-1:0] c0_tx_data,
  input  logic              c0_dc,
  input  logic              c0_lock,
  output logic              c0_tx_busy,
  input  logic              c1_tx_start,
  input  logic [DATA_W-1:0] c1_tx_data,
  input  logic              c1_dc,
  input  logic              c1_lock,
  output logic              c1_tx_busy,
  output logic              m_tx_start,
  output logic [DATA_W-1:0] m_tx_data,
  output logic              m_dc,
  input  logic              m_tx_busy,
  output logic [1:0]        cs_n,
  output logic [1:0]        grant
);
  localparam int HW = IDLE_CS_HOLD > 0 ? $clog2(IDLE_CS_HOLD + 1) : 1;

  state_t                    state_q, state_d;
  client_t                   owner_q, owner_d, rr_q, rr_d, sel;
  logic [HW-1:0]             hold_q, hold_d;
  logic                      locked_q, locked_d, own_lock, eff_lock, go, cs_on;
  logic [DATA_W-1:0]         mdata_q, mdata_d;
  logic                      mdc_q, mdc_d;
  logic [N_CLIENTS-1:0]      pend, done, sdc;
  logic [DATA_W-1:0]         sdata [N_CLIENTS];

  spi_tx_arb_port #(.DATA_W(DATA_W)) u_p0 (
    .clk(clk), .reset(reset), .tx_start_i(c0_tx_start), .tx_data_i(c0_tx_data), .dc_i(c0_dc),
    .done_i(done[0]), .tx_busy_o(pend[0]), .data_o(sdata[0]), .dc_o(sdc[0])
  );

  spi_tx_arb_port #(.DATA_W(DATA_W)) u_p1 (
    .clk(clk), .reset(reset), .tx_start_i(c1_tx_start), .tx_data_i(c1_tx_data), .dc_i(c1_dc),
    .done_i(done[1]), .tx_busy_o(pend[1]), .data_o(sdata[1]), .dc_o(sdc[1])
  );

`ifdef SPI_TX_ARB_LOCK_EN
  assign own_lock = owner_q[0] ? c1_lock : c0_lock;
`else
  logic unused_lock;
  assign unused_lock = c0_lock ^ c1_lock;
  assign own_lock    = 1'b0;
`endif

  // a held lock restricts service to the owner; the rr pointer only moves on contested grants
  assign eff_lock = locked_q && own_lock;
  assign go       = eff_lock ? pend[owner_q] : |pend;
  assign sel      = eff_lock ? owner_q : (&pend ? rr_q : client_t'(pend[1]));

  // next-state logic for the issue FSM, owner, hold timer and latched master byte
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    locked_d = locked_q;
    mdata_d  = mdata_q;
    mdc_d    = mdc_q;
    done     = '0;
    unique case (state_q)
      IDLE: begin
        hold_d   = hold_q != '0 ? hold_q - HW'(1) : hold_q;
        locked_d = eff_lock;
        if (go) begin
          state_d = ISSUE;
          owner_d = sel;
          rr_d    = (&pend && !eff_lock) ? ~sel : rr_q;
          hold_d  = '0;
          mdata_d = sdata[sel];
          mdc_d   = sdc[sel];
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = m_tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: begin
        if (!m_tx_busy) begin
          state_d  = IDLE;
          done     = onehot(owner_q);
          hold_d   = HW'(IDLE_CS_HOLD);
          locked_d = own_lock;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      hold_q   <= '0;
      locked_q <= 1'b0;
      mdata_q  <= '0;
      mdc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      locked_q <= locked_d;
      mdata_q  <= mdata_d;
      mdc_q    <= mdc_d;
    end
  end

  assign cs_on      = state_q != IDLE || hold_q != '0 || locked_q;
  assign grant      = cs_on ? onehot(owner_q) : '0;
  assign cs_n       = ~grant;
  assign m_tx_start = state_q == ISSUE;
  assign m_tx_data  = mdata_q;
  assign m_dc       = mdc_q;
  assign c0_tx_busy = pend[0];
  assign c1_tx_busy = pend[1];
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: scoreboard bench for spi_tx_arbiter with a 4-cycle master model
module tb_spi_tx_arbiter;
  typedef struct packed {
    logic [7:0] d;
    logic       dc;
    logic [1:0] cs;
  } exp_t;

  logic       clk = 1'b0, reset = 1'b0;
  logic       c0_tx_start = 1'b0, c0_dc = 1'b0, c0_lock = 1'b0, c0_tx_busy;
  logic       c1_tx_start = 1'b0, c1_dc = 1'b0, c1_lock = 1'b0, c1_tx_busy;
  logic [7:0] c0_tx_data = '0, c1_tx_data = '0, m_tx_data;
  logic       m_tx_start, m_dc, m_tx_busy;
  logic [1:0] cs_n, grant;
  logic [2:0] mcnt = '0;
  exp_t       q[$];
  int         total = 0, bad = 0, n_push = 0, n_issue = 0, viol = 0;

  spi_tx_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_tx_start(c0_tx_start), .c0_tx_data(c0_tx_data), .c0_dc(c0_dc), .c0_lock(c0_lock), .c0_tx_busy(c0_tx_busy),
    .c1_tx_start(c1_tx_start), .c1_tx_data(c1_tx_data), .c1_dc(c1_dc), .c1_lock(c1_lock), .c1_tx_busy(c1_tx_busy),
    .m_tx_start(m_tx_start), .m_tx_data(m_tx_data), .m_dc(m_dc), .m_tx_busy(m_tx_busy),
    .cs_n(cs_n), .grant(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mcnt <= m_tx_start ? 3'd4 : (mcnt != 0 ? mcnt - 3'd1 : 3'd0);
  assign m_tx_busy = mcnt != 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic dc, input logic [1:0] cs);
    q.push_back('{d: d, dc: dc, cs: cs});
    n_push++;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (cs_n == 2'b00 || cs_n !== ~grant || (grant == 2'b11)) viol++;
      if (m_tx_start) begin
        n_issue++;
        if (q.size() == 0) begin
          chk("unexpected_start", {23'd0, m_tx_data, m_dc}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("issue", {21'd0, m_tx_data, m_dc, cs_n}, {21'd0, e.d, e.dc, e.cs});
        end
      end
    end
  end

  task automatic pulse(input logic s0, input logic [7:0] d0, input logic dc0,
                       input logic s1, input logic [7:0] d1, input logic dc1);
    @(negedge clk);
    c0_tx_start = s0; c0_tx_data = d0; c0_dc = dc0;
    c1_tx_start = s1; c1_tx_data = d1; c1_dc = dc1;
    @(negedge clk);
    c0_tx_start = 1'b0; c1_tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !c0_tx_busy && !c1_tx_busy && !m_tx_start && cs_n == 2'b11;
    end
    if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_c0_free();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !c0_tx_busy;
    end
    if (!ok) chk("wait_c0_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fell;
    logic prev;
    repeat (2) @(negedge clk);
    chk("reset_state", {17'd0, m_tx_start, m_tx_data, m_dc, cs_n, grant, c0_tx_busy, c1_tx_busy},
        {17'd0, 1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0});
    reset = 1'b1;

    push(8'h2A, 1'b0, 2'b10);
    pulse(1, 8'h2A, 0, 0, 8'h00, 0);
    chk("busy_at_n1", {31'd0, c0_tx_busy}, 32'd1);
    chk("no_start_at_n1", {31'd0, m_tx_start}, 32'd0);
    @(negedge clk);
    chk("start_at_n2", {31'd0, m_tx_start}, 32'd1);
    fell = 0;
    prev = m_tx_busy;
    for (int i = 0; i < 50 && !fell; i++) begin
      @(negedge clk);
      fell = prev && !m_tx_busy;
      prev = m_tx_busy;
    end
    chk("master_busy_fell", {31'd0, fell}, 32'd1);
    chk("busy_hold_at_fall", {31'd0, c0_tx_busy}, 32'd1);
    @(negedge clk);
    chk("busy_release", {31'd0, c0_tx_busy}, 32'd0);
    wait_idle();

    do_reset();
    push(8'h11, 1'b0, 2'b10);
    push(8'h22, 1'b1, 2'b01);
    pulse(1, 8'h11, 0, 1, 8'h22, 1);
    wait_idle();
    push(8'h66, 1'b0, 2'b01);
    push(8'h44, 1'b1, 2'b10);
    pulse(1, 8'h44, 1, 1, 8'h66, 0);
    wait_idle();

    do_reset();
    c0_lock = 1'b1;
    push(8'hF8, 1'b0, 2'b10);
`ifndef SPI_TX_ARB_LOCK_EN
    push(8'h55, 1'b1, 2'b01);
`endif
    pulse(1, 8'hF8, 0, 1, 8'h55, 1);
    wait_c0_free();
`ifdef SPI_TX_ARB_LOCK_EN
    chk("lock_cs_held", {30'd0, cs_n}, {30'd0, 2'b10});
`endif
    push(8'h00, 1'b1, 2'b10);
    pulse(1, 8'h00, 1, 0, 8'h00, 0);
    wait_c0_free();
`ifdef SPI_TX_ARB_LOCK_EN
    repeat (3) @(negedge clk);
    chk("lock_c1_waits", {31'd0, c1_tx_busy}, 32'd1);
    chk("lock_cs_held2", {30'd0, cs_n}, {30'd0, 2'b10});
    push(8'h55, 1'b1, 2'b01);
`endif
    c0_lock = 1'b0;
    wait_idle();

    do_reset();
    push(8'h77, 1'b1, 2'b10);
    pulse(1, 8'h77, 1, 0, 8'h00, 0);
    fell = 0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk);
      fell = m_tx_busy;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_mid_xfer", {17'd0, m_tx_start, m_tx_data, m_dc, cs_n, grant, c0_tx_busy, c1_tx_busy},
        {17'd0, 1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    push(8'h33, 1'b0, 2'b01);
    pulse(0, 8'h00, 0, 1, 8'h33, 0);
    wait_idle();

    push(8'h5A, 1'b0, 2'b10);
    pulse(1, 8'h5A, 0, 0, 8'h00, 0);
    pulse(1, 8'hA5, 1, 0, 8'h00, 0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    chk("issue_count", n_issue, n_push);
    chk("cs_invariant", viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
